// File: rtl/free_list_pkg.sv
// Shared sizing and types for the rename free list. Dispatch branch
// checkpoints and the ROB use the same pointer and tag types.
package free_list_pkg;

  localparam int DEF_PHYS_REG_SZ = 64;
  localparam int DEF_ARCH_REG_SZ = 32;

  localparam int FL_DEPTH = DEF_PHYS_REG_SZ - DEF_ARCH_REG_SZ;
  localparam int PREG_W   = $clog2(DEF_PHYS_REG_SZ);
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int FL_PTR_W = FL_IDX_W + 1;

  // Head/tail pointer: slot index plus one wrap bit.
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  // Physical register tag.
  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags. Dispatch pops tags at the
// head, retire pushes released tags at the tail, and a branch mispredict
// rolls the head back to a checkpoint so wrong-path tags become free again.
// DEPTH (PHYS_REG_SZ - ARCH_REG_SZ) must be a power of two so that pointer
// arithmetic wraps naturally.
module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REG_SZ = DEF_PHYS_REG_SZ,
  parameter int ARCH_REG_SZ = DEF_ARCH_REG_SZ
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        dequeue_en,
  output logic [$clog2(PHYS_REG_SZ)-1:0]              free_reg,
  input  logic                                        enqueue_en,
  input  logic [$clog2(PHYS_REG_SZ)-1:0]              enqueue_pr,
  input  logic                                        restore_en,
  input  logic [$clog2(PHYS_REG_SZ-ARCH_REG_SZ):0]    restore_ptr,
  output logic [$clog2(PHYS_REG_SZ-ARCH_REG_SZ):0]    head_ptr,
  output logic                                        empty,
  output logic                                        full,
  output logic [$clog2(PHYS_REG_SZ-ARCH_REG_SZ):0]    count,
  output logic                                        overflow
);

  localparam int DEPTH = PHYS_REG_SZ - ARCH_REG_SZ;
  localparam int PR_W  = $clog2(PHYS_REG_SZ);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PR_W-1:0]  mem_q [DEPTH];
  logic [PR_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             overflow_q, overflow_d;

  logic             do_deq;
  logic             do_enq;
  logic             enq_req;
  logic [PTR_W-1:0] count_w;
  logic             empty_w;
  logic             full_w;

  // Occupancy flags from pre-edge pointers; the wrap bit separates full
  // from empty when the indices match.
  always_comb begin
    count_w = tail_q - head_q;
    empty_w = (count_w == '0);
    full_w  = (count_w == PTR_W'(DEPTH));
  end

  // Next-state: restore beats dequeue; a full list still accepts an
  // enqueue when a dequeue frees the head slot in the same cycle.
  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;

    enq_req = enqueue_en && (enqueue_pr != '0);
    do_deq  = dequeue_en && !empty_w && !restore_en;
    do_enq  = enq_req && (!full_w || do_deq);

    if (enq_req && !do_enq) begin
      overflow_d = 1'b1;
    end

    if (do_enq) begin
      mem_d[tail_q[IDX_W-1:0]] = enqueue_pr;
      tail_d                   = tail_q + PTR_W'(1);
    end

    if (restore_en) begin
      head_d = restore_ptr;
    end else if (do_deq) begin
      head_d = head_q + PTR_W'(1);
    end
  end

  // State registers; reset reloads the tags above the architectural range
  // and marks every slot free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PR_W'(ARCH_REG_SZ + i);
      end
      head_q     <= '0;
      tail_q     <= PTR_W'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs are direct views of the current state, with no enqueue bypass.
  always_comb begin
    free_reg = mem_q[head_q[IDX_W-1:0]];
    head_ptr = head_q;
    count    = count_w;
    empty    = empty_w;
    full     = full_w;
    overflow = overflow_q;
  end

endmodule
